// File: rtl/inst_fetch_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_if
// Bundles every non-clock/reset signal of the instruction fetch stage:
//   - instruction memory request  (imem_req_valid/ready, imem_addr)
//   - instruction memory response (imem_rsp_valid, imem_rsp_data), in order
//   - PC redirect from execute    (redirect_valid, redirect_pc)
//   - decode hand-off             (id_valid/ready, id_pc, id_inst, id_rs2,
//                                  id_funct7, id_type[, id_misalign])
// Modports:
//   master : the fetch stage itself
//   slave  : the environment (memory, execute and decode stages)
// Optional macro IFU_MISALIGN_CHK_EN adds the id_misalign signal.
// ---------------------------------------------------------------------------
`ifndef TYPE_BUS
`define TYPE_BUS 1:0
`endif
`ifndef INST_R
`define INST_R 2'd0
`endif
`ifndef INST_I
`define INST_I 2'd1
`endif

interface inst_fetch_if;
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [31:0]      imem_addr;
  logic             imem_rsp_valid;
  logic [31:0]      imem_rsp_data;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             id_valid;
  logic             id_ready;
  logic [31:0]      id_pc;
  logic [31:0]      id_inst;
  logic [4:0]       id_rs2;
  logic [6:0]       id_funct7;
  logic [`TYPE_BUS] id_type;
`ifdef IFU_MISALIGN_CHK_EN
  logic             id_misalign;
`endif

  modport master (
    output imem_req_valid, imem_addr,
    output id_valid, id_pc, id_inst, id_rs2, id_funct7, id_type,
`ifdef IFU_MISALIGN_CHK_EN
    output id_misalign,
`endif
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    input  id_valid, id_pc, id_inst, id_rs2, id_funct7, id_type,
`ifdef IFU_MISALIGN_CHK_EN
    input  id_misalign,
`endif
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
// Instruction fetch stage. Owns the PC, issues one fetch at a time to
// instruction memory, captures the returned word in the instruction register
// (IR) and offers it to decode together with rs2, funct7 and a coarse
// instruction type. Execute can redirect the PC at any time; an in-flight
// fetch is then squashed.
//
// Ports:
//   clk  in  single clock, all state on the rising edge
//   rst  in  synchronous, active-high reset
//   bus  inst_fetch_if.master (memory request/response, redirect, decode)
//
// Parameters:
//   RESET_PC  PC loaded on reset
//   PC_STEP   PC increment after each consumed instruction
//
// Optional macro IFU_MISALIGN_CHK_EN: a PC with pc[1:0]!=0 is not fetched;
// instead a nop is presented with id_misalign=1. Without the macro the PC is
// sent to memory unchecked.
// ---------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_OUT   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [31:0]      r_pc;
  logic [31:0]      r_ir;
  logic [31:0]      r_id_pc;
  logic             w_req_valid;
  logic             w_id_valid;
  logic             w_req_fire;
  logic             w_rsp_take;
  logic             w_consume;
  logic             w_misalign;
  logic [`TYPE_BUS] w_type;

`ifdef IFU_MISALIGN_CHK_EN
  logic r_misalign;
  logic w_misalign_take;
  assign w_misalign      = (r_pc[1:0] != 2'b00);
  // A misaligned PC is turned into a local "fetch" of a nop unless a
  // redirect replaces the PC in the same cycle.
  assign w_misalign_take = (r_state == S_REQ) && w_misalign && !bus.redirect_valid;
`else
  assign w_misalign = 1'b0;
`endif

  assign w_req_fire = w_req_valid && bus.imem_req_ready;
  // A response arriving together with a redirect belongs to the old path.
  assign w_rsp_take = (r_state == S_WAIT) && bus.imem_rsp_valid && !bus.redirect_valid;
  assign w_consume  = w_id_valid && bus.id_ready;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: w_state_next = S_REQ;
      S_REQ: begin
        if (bus.redirect_valid) begin
          // An accepted request still owes us a response: drain it.
          w_state_next = w_req_fire ? S_DRAIN : S_REQ;
        end else if (w_misalign) begin
          w_state_next = S_OUT;
        end else if (bus.imem_req_ready) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.redirect_valid) begin
          w_state_next = bus.imem_rsp_valid ? S_REQ : S_DRAIN;
        end else if (bus.imem_rsp_valid) begin
          w_state_next = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.redirect_valid || bus.id_ready) begin
          w_state_next = S_REQ;
        end
      end
      S_DRAIN: begin
        if (bus.imem_rsp_valid) begin
          w_state_next = S_REQ;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_req_valid = 1'b0;
    w_id_valid  = 1'b0;
    case (r_state)
      S_REQ:   w_req_valid = !w_misalign;
      S_OUT:   w_id_valid  = 1'b1;
      default: begin
        w_req_valid = 1'b0;
        w_id_valid  = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // PC, IR and the PC captured alongside the IR
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_ir    <= NOP;
      r_id_pc <= RESET_PC;
    end else begin
      // Redirect wins over the sequential step, even when the instruction
      // in IR is consumed in the same cycle.
      if (bus.redirect_valid) begin
        r_pc <= bus.redirect_pc;
      end else if (w_consume) begin
        r_pc <= r_pc + PC_STEP;
      end

      if (w_rsp_take) begin
        r_ir    <= bus.imem_rsp_data;
        r_id_pc <= r_pc;
      end
`ifdef IFU_MISALIGN_CHK_EN
      else if (w_misalign_take) begin
        r_ir    <= NOP;
        r_id_pc <= r_pc;
      end
`endif
    end
  end

`ifdef IFU_MISALIGN_CHK_EN
  // Flag follows whatever last wrote the IR.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (w_rsp_take) begin
      r_misalign <= 1'b0;
    end else if (w_misalign_take) begin
      r_misalign <= 1'b1;
    end
  end
  assign bus.id_misalign = r_misalign;
`endif

  // Only R-type ALU ops and the I-format opcodes are distinguished; every
  // other opcode is reported as R so decode sees a defined value.
  always_comb begin
    w_type = `INST_R;
    case (r_ir[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: w_type = `INST_I;
      default:                            w_type = `INST_R;
    endcase
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_addr      = r_pc;
  assign bus.id_valid       = w_id_valid;
  assign bus.id_pc          = r_id_pc;
  assign bus.id_inst        = r_ir;
  assign bus.id_rs2         = r_ir[24:20];
  assign bus.id_funct7      = r_ir[31:25];
  assign bus.id_type        = w_type;

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
// Drives inst_fetch with a behavioural instruction memory (random ready and
// response latency), random redirects, decode back-pressure and occasional
// resets. A reference model tracks the architectural PC stream and queues
// the instruction decode must see next; a monitor compares every newly
// presented instruction against it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`ifndef TYPE_BUS
`define TYPE_BUS 1:0
`endif
`ifndef INST_R
`define INST_R 2'd0
`endif
`ifndef INST_I
`define INST_I 2'd1
`endif

module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  logic clk;
  logic rst;
  inst_fetch_if bus ();

  inst_fetch #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks   = 0;
  int          n_fail     = 0;
  int          n_consumed = 0;
  int          ready_pct  = 100;
  int          min_dly    = 0;
  int          max_dly    = 0;
  logic [31:0] model_pc   = RESET_PC;
  exp_t        exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory image: two fixed words at the reset vector, the rest synthesized
  // from the address with a mix of R, I and other opcodes.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0]  opc;
    logic [24:0] body;
    if (a == 32'h8000_0000) return 32'h0050_0093;
    if (a == 32'h8000_0004) return 32'h0020_81B3;
    case (a[4:2])
      3'd0:    opc = 7'b0110011;
      3'd1:    opc = 7'b0010011;
      3'd2:    opc = 7'b0000011;
      3'd3:    opc = 7'b1100111;
      3'd4:    opc = 7'b0110111;
      3'd5:    opc = 7'b1100011;
      3'd6:    opc = 7'b0110011;
      default: opc = 7'b0100011;
    endcase
    body = (a[26:2] * 25'd40503) ^ 25'h15A5A5A;
    return {body, opc};
  endfunction

  function automatic logic [`TYPE_BUS] ref_type(input logic [31:0] inst);
    if (inst[6:0] == 7'b0010011 || inst[6:0] == 7'b0000011 || inst[6:0] == 7'b1100111)
      return `INST_I;
    return `INST_R;
  endfunction

  function automatic exp_t make_exp(input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
`ifdef IFU_MISALIGN_CHK_EN
    if (pc[1:0] != 2'b00) begin
      e.inst = NOP;
      e.mis  = 1'b1;
      return e;
    end
`endif
    e.inst = mem_word(pc);
    e.mis  = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(3))
      0:       t = 32'hFFFF_FFF8;
      1, 2:    t = 32'h8000_0000 | ($urandom & 32'h0000_0FFC);
      default: t = $urandom & 32'hFFFF_FFFC;
    endcase
`ifdef IFU_MISALIGN_CHK_EN
    if ($urandom_range(3) == 0) t = t | 32'($urandom_range(3));
`endif
    return t;
  endfunction

  // -------------------------------------------------------------------------
  // Instruction memory: one outstanding request, in-order response after a
  // random latency of at least one cycle. Runs at negedge+1.
  // -------------------------------------------------------------------------
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_dly = 0;

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      bus.imem_rsp_valid = 1'b0;
      if (rst) begin
        pend               = 1'b0;
        bus.imem_req_ready = 1'b0;
      end else begin
        if (pend) begin
          if (pend_dly == 0) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pend_addr);
            pend               = 1'b0;
          end else begin
            pend_dly--;
          end
        end
        bus.imem_req_ready = ($urandom_range(99) < ready_pct);
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          chk("one_outstanding", {31'd0, pend}, 32'd0);
          if (!bus.redirect_valid) chk("req_addr", bus.imem_addr, model_pc);
`ifdef IFU_MISALIGN_CHK_EN
          chk("req_aligned", {30'd0, bus.imem_addr[1:0]}, 32'd0);
`endif
          pend      = 1'b1;
          pend_addr = bus.imem_addr;
          pend_dly  = $urandom_range(max_dly, min_dly);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Monitor + reference model. Runs at negedge+2, after all inputs for the
  // coming edge are settled.
  // -------------------------------------------------------------------------
  logic presented = 1'b0;
  logic rst_prev  = 1'b1;
  exp_t cur;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_prev) begin
        chk("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
      end
      if (rst) begin
        presented = 1'b0;
        model_pc  = RESET_PC;
        exp_q.delete();
        exp_q.push_back(make_exp(model_pc));
      end else begin
        chk("no_req_in_out", {31'd0, bus.imem_req_valid && bus.id_valid}, 32'd0);
        if (bus.id_valid && !presented) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_inst", bus.id_pc, 32'hXXXX_XXXX);
          end else begin
            cur = exp_q.pop_front();
            chk("id_pc", bus.id_pc, cur.pc);
            chk("id_inst", bus.id_inst, cur.inst);
            chk("id_rs2", {27'd0, bus.id_rs2}, {27'd0, cur.inst[24:20]});
            chk("id_funct7", {25'd0, bus.id_funct7}, {25'd0, cur.inst[31:25]});
            chk("id_type", 32'(bus.id_type), 32'(ref_type(cur.inst)));
`ifdef IFU_MISALIGN_CHK_EN
            chk("id_misalign", {31'd0, bus.id_misalign}, {31'd0, cur.mis});
`endif
          end
          presented = 1'b1;
        end else if (presented) begin
          chk("hold_valid", {31'd0, bus.id_valid}, 32'd1);
          chk("hold_inst", bus.id_inst, cur.inst);
          chk("hold_pc", bus.id_pc, cur.pc);
        end
        if (bus.redirect_valid) begin
          if (presented && bus.id_ready) n_consumed++;
          presented = 1'b0;
          model_pc  = bus.redirect_pc;
          exp_q.delete();
          exp_q.push_back(make_exp(model_pc));
        end else if (presented && bus.id_ready) begin
          n_consumed++;
          presented = 1'b0;
          model_pc  = model_pc + 32'd4;
          exp_q.push_back(make_exp(model_pc));
        end
      end
      rst_prev = rst;
    end
  end

  task automatic wait_valid(input string name);
    int n = 0;
    while (bus.id_valid !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, bus.id_valid}, 32'd1);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus (runs at negedge)
  // -------------------------------------------------------------------------
  initial begin
    int lat;
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // First instruction: three edges after reset release.
    lat = 0;
    while (bus.id_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("t1_latency", lat, 3);
    chk("t1_type", 32'(bus.id_type), 32'(`INST_I));
    chk("t1_rs2", {27'd0, bus.id_rs2}, 32'd5);
    chk("t1_funct7", {25'd0, bus.id_funct7}, 32'd0);
    chk("t1_pc", bus.id_pc, 32'h8000_0000);
    @(negedge clk);

    // Back-pressure: held for 5 more cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_valid", {31'd0, bus.id_valid}, 32'd1);
      chk("t2_inst", bus.id_inst, 32'h0050_0093);
      chk("t2_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    end
    min_dly      = 1;
    max_dly      = 1;
    bus.id_ready = 1'b1;
    @(negedge clk);
    bus.id_ready = 1'b0;
    wait_valid("t4_valid");
    chk("t4_type", 32'(bus.id_type), 32'(`INST_R));
    chk("t4_rs2", {27'd0, bus.id_rs2}, 32'd2);
    chk("t4_pc", bus.id_pc, 32'h8000_0004);

    // Redirect while waiting; the late response must be dropped.
    bus.id_ready = 1'b1;
    @(negedge clk);
    bus.id_ready = 1'b0;
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0100;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    wait_valid("t3_valid");
    chk("t3_pc", bus.id_pc, 32'h8000_0100);
    chk("t3_inst", bus.id_inst, mem_word(32'h8000_0100));

    // Reset while waiting for a response.
    bus.id_ready = 1'b1;
    @(negedge clk);
    bus.id_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_idle_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("t5_idle_req", {31'd0, bus.imem_req_valid}, 32'd0);
    @(negedge clk);
    chk("t5_req", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("t5_addr", bus.imem_addr, 32'h8000_0000);
    wait_valid("t5_valid");
    chk("t5_pc", bus.id_pc, 32'h8000_0000);

`ifdef IFU_MISALIGN_CHK_EN
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0002;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("t6_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    @(negedge clk);
    chk("t6_valid", {31'd0, bus.id_valid}, 32'd1);
    chk("t6_misalign", {31'd0, bus.id_misalign}, 32'd1);
    chk("t6_pc", bus.id_pc, 32'h8000_0002);
    chk("t6_inst", bus.id_inst, NOP);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0000;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
`endif

    // Random phase.
    ready_pct = 70;
    min_dly   = 0;
    max_dly   = 3;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst                = ($urandom_range(499) == 0);
      bus.id_ready       = ($urandom_range(2) != 0);
      bus.redirect_valid = ($urandom_range(9) == 0);
      bus.redirect_pc    = pick_target();
    end
    @(negedge clk);
    rst                = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.id_ready       = 1'b1;
    repeat (20) @(negedge clk);
    chk("progress", {31'd0, (n_consumed > 50)}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
